seq_addsub_32bit: RTL and testbench

- Multi-cycle slice-serial adder that sits directly downstream of the 32-bit conditional-invert (XOR) stage.
- Consumes operand A plus the already conditionally inverted operand B, and takes the subtract/invert bit as carry-in. It therefore performs A+B or A-B (two's complement).
- Adds SLICE bits per cycle with a registered carry, then presents result, carry, overflow and zero flags under a start/done handshake.
- Replaces a full-width ripple adder where area matters more than latency.

---
 rtl/seq_addsub_32bit.sv | 153 +++++++++++++++
 tb/tb_seq_addsub_32bit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_32bit.sv
// Slice-serial adder/subtractor: consumes A, pre-inverted B and carry-in,
// adds SLICE bits per cycle and reports result plus carry/overflow/zero flags.
module seq_addsub_32bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_x,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SUM_W  = SLICE + 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_c;
  logic               last_c;
  logic [31:0]        shamt_c;
  logic [SLICE-1:0]   a_sl_c;
  logic [SLICE-1:0]   b_sl_c;
  logic [SUM_W-1:0]   sum_c;
  logic [WIDTH-1:0]   merged_c;
  logic               msb_cin_c;

  // A new operation is accepted only when no operation is in flight.
  assign accept_c = start && (state_q != S_RUN);
  assign last_c   = (cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Current slice add; the MSB carry-in is recovered from the MSB sum bit.
  always_comb begin
    shamt_c   = 32'(cnt_q) * SLICE;
    a_sl_c    = SLICE'(a_q >> shamt_c);
    b_sl_c    = SLICE'(b_q >> shamt_c);
    sum_c     = SUM_W'(a_sl_c) + SUM_W'(b_sl_c) + SUM_W'(carry_q);
    merged_c  = (result_q & ~(SLICE_MASK << shamt_c))
              | (WIDTH'(sum_c[SLICE-1:0]) << shamt_c);
    msb_cin_c = a_sl_c[SLICE-1] ^ b_sl_c[SLICE-1] ^ sum_c[SLICE-1];
  end

  // Datapath and output next values.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    busy_d   = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    if (accept_c) begin
      a_d      = a;
      b_d      = b_x;
      carry_d  = cin;
      cnt_d    = '0;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      zero_d   = 1'b0;
    end else if (state_q == S_RUN) begin
      result_d = merged_c;
      carry_d  = sum_c[SLICE];
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_c) begin
        cout_d = sum_c[SLICE];
        ovf_d  = msb_cin_c ^ sum_c[SLICE];
        zero_d = (merged_c == '0);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_addsub_32bit.sv
// Self-checking bench for seq_addsub_32bit: directed table, random ops and
// handshake / reset corner sequences.
module tb_seq_addsub_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b_x;
  logic        cin;
  logic [31:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  seq_addsub_32bit #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b_x(b_x), .cin(cin),
    .result(result), .cout(cout), .overflow(overflow), .zero(zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain two's complement arithmetic on full-width values.
  task automatic model(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       output vec_t v);
    logic [32:0] s;
    s = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    v.a = av; v.b = bv; v.c = cv;
    v.r  = s[31:0];
    v.co = s[32];
    v.ov = (av[31] == bv[31]) && (s[31] != av[31]);
    v.z  = (s[31:0] == 32'd0);
  endtask

  // Drive a one-cycle start; returns at the negedge after the accepting edge
  // with the inputs scrambled so only latched copies can be used.
  task automatic pulse_start(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    @(negedge clk);
    a = av; b_x = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b_x = $urandom; cin = 1'($urandom);
  endtask

  // Wait (bounded) for done, counting busy samples seen before it.
  task automatic wait_done(output int busy_n, output bit got);
    busy_n = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_flags(input string tag, input vec_t v);
    check({tag, ".result"},   result,          v.r);
    check({tag, ".cout"},     32'(cout),       32'(v.co));
    check({tag, ".overflow"}, 32'(overflow),   32'(v.ov));
    check({tag, ".zero"},     32'(zero),       32'(v.z));
    check({tag, ".busy_at_done"}, 32'(busy),   32'd0);
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int busy_n;
    bit got;
    pulse_start(v.a, v.b, v.c);
    wait_done(busy_n, got);
    check({tag, ".done_seen"},   32'(got),    32'd1);
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'd8);
    check_flags(tag, v);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    check({tag, ".result_hold"},    result,    v.r);
  endtask

  vec_t tbl[7];
  vec_t v, v2;
  int   busy_n;
  bit   got;
  int   done_cnt;

  initial begin
    tbl[0] = '{32'd5,        32'd3,        1'b0, 32'd8,        1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'd5,        32'hFFFFFFFC, 1'b1, 32'd2,        1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'd3,        32'hFFFFFFFA, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h00001234, 32'hFFFFEDCB, 1'b1, 32'd0,        1'b1, 1'b0, 1'b1};
    tbl[5] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'd0,        1'b1, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b_x = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset.result", result, 32'd0);
    check("reset.flags", {28'd0, cout, overflow, zero, busy | done}, 32'd0);

    foreach (tbl[i]) run_op($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 20; i++) begin
      model($urandom, $urandom, 1'($urandom), v);
      if (i % 2 == 1) begin
        v2 = v;
        model(v2.a, ~v2.b, 1'b1, v);
      end
      run_op($sformatf("rnd%0d", i), v);
    end

    // start re-pulsed during RUN cycle 3 must be ignored
    model(32'h0000_1111, 32'h2222_0000, 1'b0, v);
    pulse_start(v.a, v.b, v.c);
    repeat (2) @(negedge clk);
    a = 32'hDEAD_BEEF; b_x = 32'h1234_5678; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(busy_n, got);
    check("ignore.done_seen", 32'(got), 32'd1);
    check("ignore.busy_rest", 32'(busy_n), 32'd5);
    check_flags("ignore", v);

    // start held in the DONE cycle launches a back-to-back op
    model(32'h0F0F_0F0F, 32'h1010_1010, 1'b1, v2);
    a = v2.a; b_x = v2.b; cin = v2.c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.done_dropped", 32'(done), 32'd0);
    wait_done(busy_n, got);
    check("b2b.done_seen", 32'(got), 32'd1);
    check("b2b.busy_cycles", 32'(busy_n), 32'd8);
    check_flags("b2b", v2);
    @(negedge clk);
    check("b2b.done_one_cycle", 32'(done), 32'd0);

    // reset during RUN cycle 5 discards the op with no done pulse
    model(32'hFFFF_0000, 32'h0001_FFFF, 1'b0, v);
    pulse_start(v.a, v.b, v.c);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid.result", result, 32'd0);
    check("rst_mid.flags", {27'd0, cout, overflow, zero, busy, done}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("rst_mid.no_done", 32'(done_cnt), 32'd0);
    run_op("after_rst", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
